// File: rtl/taus113_reseed_ctrl_if.sv
// Seed-request and random-word stream bundle for taus113_reseed_ctrl.
// The slave modport is the controller side; the master modport is the seed source / consumer side.
interface taus113_reseed_ctrl_if;
  localparam int unsigned DATA_W = 32;

  logic [DATA_W-1:0] seed_in;
  logic              seed_valid;
  logic              seed_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output seed_in, seed_valid, out_ready,
    input  seed_ready, out_data, out_valid
  );

  modport slave (
    input  seed_in, seed_valid, out_ready,
    output seed_ready, out_data, out_valid
  );
endinterface

// File: rtl/taus113_reseed_ctrl.sv
// Reseed controller for a taus113 generator: loads seeds, waits for settling, then streams words.
// Optional self-reseed every AUTO_PERIOD accepted words is enabled by defining RESEED_CTRL_AUTO_EN.
module taus113_reseed_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [31:0] DEFAULT_SEED  = 32'h1234_5678,
  parameter int unsigned AUTO_PERIOD   = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  taus113_reseed_ctrl_if.slave        bus,
  output logic [31:0]                 rng_seed,
  output logic                        rng_reseed,
  input  logic [31:0]                 rng_rnd,
  output logic [31:0]                 word_cnt,
  output logic                        busy
);

  localparam int unsigned   CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [31:0]   AUTO_LAST   = 32'(AUTO_PERIOD - 1);
  localparam logic [31:0]   SEED_STEP   = 32'h9E37_79B9;
`ifdef RESEED_CTRL_AUTO_EN
  localparam bit            AUTO_EN     = 1'b1;
`else
  localparam bit            AUTO_EN     = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [31:0]      seed_q, seed_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             reseed_q, reseed_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic             seed_hs;
  logic             deliver;
  logic             auto_hit;
  logic [31:0]      ext_seed;
  logic [31:0]      auto_sum;
  logic [31:0]      auto_seed;

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    seed_d    = seed_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;

    seed_hs   = bus.seed_valid && ready_q;
    deliver   = valid_q && bus.out_ready;
    auto_hit  = AUTO_EN && deliver && (cnt_q == AUTO_LAST);
    ext_seed  = (bus.seed_in == 32'd0) ? DEFAULT_SEED : bus.seed_in;
    auto_sum  = seed_q + SEED_STEP;
    auto_seed = (auto_sum == 32'd0) ? DEFAULT_SEED : auto_sum;

    case (state_q)
      ST_IDLE: begin
        if (seed_hs) begin
          seed_d  = ext_seed;
          cnt_d   = 32'd0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        settle_d = '0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          data_d  = rng_rnd;
          valid_d = 1'b1;
          cnt_d   = 32'd0;
          state_d = ST_RUN;
        end else begin
          settle_d = settle_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        // An external seed wins over both delivery and auto-reseed; the pending word is dropped
        if (seed_hs) begin
          seed_d  = ext_seed;
          valid_d = 1'b0;
          cnt_d   = 32'd0;
          state_d = ST_LOAD;
        end else if (auto_hit) begin
          seed_d  = auto_seed;
          valid_d = 1'b0;
          cnt_d   = 32'd0;
          state_d = ST_LOAD;
        end else if (deliver) begin
          data_d = rng_rnd;
          cnt_d  = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    reseed_d = (state_d == ST_LOAD);
    busy_d   = (state_d == ST_LOAD) || (state_d == ST_SETTLE);
    ready_d  = !busy_d;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      seed_q   <= DEFAULT_SEED;
      data_q   <= 32'd0;
      cnt_q    <= 32'd0;
      valid_q  <= 1'b0;
      reseed_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      seed_q   <= seed_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      reseed_q <= reseed_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.seed_ready = ready_q;
  assign bus.out_data   = data_q;
  assign bus.out_valid  = valid_q;
  assign rng_seed       = seed_q;
  assign rng_reseed     = reseed_q;
  assign word_cnt       = cnt_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_taus113_reseed_ctrl.sv
// Self-checking bench for taus113_reseed_ctrl: random generator words and handshakes
// checked every cycle against a countdown-based reference model.
module tb_taus113_reseed_ctrl;

  localparam int unsigned SETTLE   = 2;
  localparam int unsigned PERIOD   = 4;
  localparam logic [31:0] DEF_SEED = 32'h1234_5678;
  localparam logic [31:0] STEP     = 32'h9E37_79B9;
`ifdef RESEED_CTRL_AUTO_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rng_seed;
  logic        rng_reseed;
  logic [31:0] rng_rnd;
  logic [31:0] word_cnt;
  logic        busy;

  taus113_reseed_ctrl_if bus ();

  taus113_reseed_ctrl #(
    .SETTLE_CYCLES (SETTLE),
    .DEFAULT_SEED  (DEF_SEED),
    .AUTO_PERIOD   (PERIOD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .rng_seed   (rng_seed),
    .rng_reseed (rng_reseed),
    .rng_rnd    (rng_rnd),
    .word_cnt   (word_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: m_wait counts cycles left before a word becomes valid after a reseed
  logic [31:0] m_seed;
  logic [31:0] m_data;
  logic [31:0] m_cnt;
  logic        m_valid;
  int          m_wait;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_seed  = DEF_SEED;
    m_data  = 32'd0;
    m_cnt   = 32'd0;
    m_valid = 1'b0;
    m_wait  = 0;
  endtask

  task automatic compare_all();
    check32("seed_ready", 32'(bus.seed_ready), 32'(m_wait == 0));
    check32("busy",       32'(busy),           32'(m_wait > 0));
    check32("rng_reseed", 32'(rng_reseed),     32'(m_wait == int'(SETTLE) + 1));
    check32("rng_seed",   rng_seed,            m_seed);
    check32("out_valid",  32'(bus.out_valid),  32'(m_valid));
    check32("out_data",   bus.out_data,        m_data);
    check32("word_cnt",   word_cnt,            m_cnt);
  endtask

  // One clock: check outputs at negedge, drive fresh inputs, advance the model for the next posedge
  task automatic step(input bit r, input bit sv, input logic [31:0] sin, input bit ordy);
    logic [31:0] rnd;
    @(negedge clk);
    compare_all();
    rnd            = $urandom();
    rst            = r;
    bus.seed_valid = sv;
    bus.seed_in    = sin;
    bus.out_ready  = ordy;
    rng_rnd        = rnd;
    if (r) begin
      model_reset();
    end else if (sv && m_wait == 0) begin
      m_seed  = (sin == 32'd0) ? DEF_SEED : sin;
      m_valid = 1'b0;
      m_cnt   = 32'd0;
      m_wait  = int'(SETTLE) + 1;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_data  = rnd;
        m_valid = 1'b1;
        m_cnt   = 32'd0;
      end
    end else if (m_valid && ordy) begin
      if (AUTO && m_cnt == 32'(PERIOD - 1)) begin
        m_seed  = m_seed + STEP;
        if (m_seed == 32'd0) m_seed = DEF_SEED;
        m_valid = 1'b0;
        m_cnt   = 32'd0;
        m_wait  = int'(SETTLE) + 1;
      end else begin
        m_data = rnd;
        m_cnt  = m_cnt + 32'd1;
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.seed_valid = 1'b0;
    bus.seed_in    = 32'd0;
    bus.out_ready  = 1'b1;
    rng_rnd        = 32'd0;
    model_reset();

    repeat (2) step(1'b1, 1'b0, 32'd0, 1'b1);

    // Seed, then run with the consumer always ready
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    repeat (7) step(1'b0, 1'b0, 32'd0, 1'b1);

    // Reseed while running, ready high in the same cycle
    step(1'b0, 1'b1, 32'hCAFE_BABE, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'd0, 1'b1);

    // Backpressure for five cycles, then release
    repeat (5) step(1'b0, 1'b0, 32'd0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1);

    // Zero seed substitution and a request held through LOAD/SETTLE
    step(1'b0, 1'b1, 32'd0, 1'b1);
    repeat (3) step(1'b0, 1'b1, 32'h1111_2222, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'd0, 1'b1);

    // Reset while settling aborts the load
    step(1'b0, 1'b1, 32'h0BAD_F00D, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 32'd0, 1'b1);

    // Long run to exercise auto-reseed epochs when enabled
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    repeat (20) step(1'b0, 1'b0, 32'd0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit          r;
      bit          sv;
      bit          ordy;
      logic [31:0] sin;
      r    = ($urandom_range(0, 299) == 0);
      sv   = ($urandom_range(0, 14) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      sin  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom());
      step(r, sv, sin, ordy);
    end

    @(negedge clk);
    compare_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
